// File: rtl/rvskid_buf.sv
// rvskid_buf: two-entry elastic pipeline register (skid buffer) with
// valid/ready handshakes on both sides. One beat of backpressure is absorbed
// in the skid entry, so in_ready is a flop output with no combinational path
// from out_ready.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst_l      asynchronous active-low reset
//   flush      synchronous discard of all held beats
//   in_valid   upstream beat offered
//   in_ready   buffer can accept a beat (registered)
//   in_data    upstream payload, sampled only on in_valid & in_ready
//   out_valid  main entry holds a beat (registered)
//   out_ready  downstream accepts the beat this cycle
//   out_data   main-entry payload (registered)
//   count      number of held beats, 0..2
module rvskid_buf #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] skid;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // in_ready/out_valid/count are flops updated in lockstep with state so each
  // always equals its state decode without a combinational output path.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= EMPTY;
      out_data  <= '0;
      skid      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      count     <= 2'd0;
    end else if (flush) begin
      // Held contents are left in place but hidden by out_valid=0.
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      count     <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state     <= ONE;
            out_data  <= in_data;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
            count     <= 2'd1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            out_data <= in_data;
          end else if (in_fire) begin
            state    <= FULL;
            skid     <= in_data;
            in_ready <= 1'b0;
            count    <= 2'd2;
          end else if (out_fire) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            count     <= 2'd0;
          end
        end
        FULL: begin
          if (out_fire) begin
            state    <= ONE;
            out_data <= skid;
            in_ready <= 1'b1;
            count    <= 2'd1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          count     <= 2'd0;
        end
      endcase
    end
  end

endmodule
